m_dm: RTL
=========

Name: m_dm

Overview:
- M-stage data memory for the 5-stage MIPS pipeline.
- Consumes the E->M pipeline outputs (PC, instruction, ALU result as byte address, forwarded rt as store data).
- Decodes the load/store opcode itself, performs sub-word stores with byte enables, and returns sign- or zero-extended load data to the M->W register.
- Flags misaligned or out-of-range accesses.

Parameters:
- ADDR_W, 12, word-address width; the memory holds 2^ADDR_W 32-bit words.
- BASE, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  system clock; all writes on rising edge
- rst  in  1  asynchronous, active-low reset
- M_PC  in  32  PC of the instruction in M
- M_IR  in  32  instruction in M; opcode is [31:26]
- M_ALUO  in  32  effective byte address
- M_rt  in  32  store data (already forwarded)
- M_DMRD  out  32  extended load data; combinational
- M_AdEL  out  1  load address error; combinational
- M_AdES  out  1  store address error; combinational
- M_wcnt  out  32  count of committed stores; registered

Behaviour:
- Opcode decode:
  - Stores: sw 101011, sh 101001, sb 101000.
  - Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - Any other opcode is a non-memory instruction: no write, M_DMRD=0, both error flags 0.
- Addressing: offset = M_ALUO - BASE; word index = offset[ADDR_W+1:2]; byte lane = offset[1:0].
- Range check: an access is in range when offset < 4*2^ADDR_W (unsigned compare).
- Alignment:
  - Word accesses require lane == 0.
  - Half accesses require lane[0] == 0.
  - Byte accesses are always aligned.
- Errors:
  - M_AdEL = load AND (misaligned OR out of range).
  - M_AdES = store AND (misaligned OR out of range).
  - An erroring store writes nothing and does not increment M_wcnt.
  - An erroring load returns M_DMRD=0.
- Store byte enables:
  - sw: be=4'b1111 with data M_rt.
  - sh: be=4'b0011 (lane 0) or 4'b1100 (lane 2); data = {M_rt[15:0], M_rt[15:0]}.
  - sb: be = 1<<lane; data = {4{M_rt[7:0]}}.
  - Only enabled bytes change; the write occurs on the rising clk edge.
- Load path:
  - Combinational read of the addressed word, then lane select.
  - lh/lb sign-extend; lhu/lbu zero-extend; lw returns the full word.
- Read-during-write:
  - Same-cycle read of the word being written returns the OLD contents.
  - The new value is visible from the next cycle.
  - This holds because only one instruction occupies M at a time.
- Store counter: M_wcnt increments by 1 on each committed store. It wraps from 32'hFFFF_FFFF to 0.
- Reset:
  - rst low clears every memory word to 0 and M_wcnt to 0, immediately and independent of clk.
  - A store present while rst is low is discarded.
  - Release of rst takes effect from the next rising edge.
- Bubble handling: flushed bubbles arrive as M_IR=0 (opcode 000000, non-memory), so no write and no flags result.

Optional Feature:
- Macro: DM_DISPLAY_EN.
- Defined: each committed store, at its clock edge, prints one line "@<M_PC hex8>: *<word-aligned byte addr hex8> <= <full merged word hex8>". Erroring stores print nothing.
- Undefined: no display code is compiled; function is identical otherwise.

Test Plan:
- Reset then read: rst low 2 cycles, release; lw at 0x0, 0x4, 0xFFC -> M_DMRD=0 each, M_wcnt=0.
- Word round trip: sw M_rt=0xDEADBEEF at 0x10; next cycle lw 0x10 -> 0xDEADBEEF, M_wcnt=1.
- Sub-word stores and loads:
  - Start from word 0x10 = 0xDEADBEEF; sb 0x80 at 0x11 -> word 0xDEAD80EF.
  - lb 0x11 -> 0xFFFFFF80; lbu 0x11 -> 0x00000080.
  - sh 0x1234 at 0x12 -> word 0x123480EF; lh 0x12 -> 0x00001234.
- Misalignment:
  - sw at 0x13 -> M_AdES=1, memory unchanged, M_wcnt unchanged.
  - lh at 0x11 -> M_AdEL=1, M_DMRD=0.
  - lb at 0x13 -> no error.
- Out of range: ADDR_W=12, lw at 0x4000 -> M_AdEL=1; sb at 0x3FFF -> writes byte 3 of word 0xFFF, no error.
- Reset mid-operation: store pending and rst pulsed low asynchronously mid-cycle -> all words 0, M_wcnt=0, store not committed; with DM_DISPLAY_EN defined, no line printed.

Source files
------------

// File: rtl/m_dm.sv
// M-stage data memory: decodes load/store opcodes, performs byte-enabled
// stores and extended loads, flags address errors. Optional: DM_DISPLAY_EN.
module m_dm #(
   parameter int          ADDR_W = 12,
   parameter logic [31:0] BASE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] M_PC,
   input  logic [31:0] M_IR,
   input  logic [31:0] M_ALUO,
   input  logic [31:0] M_rt,
   output logic [31:0] M_DMRD,
   output logic        M_AdEL,
   output logic        M_AdES,
   output logic [31:0] M_wcnt
);

   localparam int          DEPTH = 1 << ADDR_W;
   localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } size_e;

   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       wcnt_q;
   logic [31:0]       wcnt_d;

   logic [5:0]        op;
   logic              is_ld;
   logic              is_st;
   logic              sext;
   size_e             sz;

   logic [31:0]       off;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        lane;
   logic              in_rng;
   logic              algn;
   logic              err;
   logic              st_ok;

   logic [3:0]        be;
   logic [31:0]       wdata;
   logic [31:0]       rword;
   logic [31:0]       wmerge;
   logic [31:0]       ldata;
   logic [15:0]       hsel;
   logic [7:0]        bsel;

   logic              unused_ok;

   assign op = M_IR[31:26];

   // Opcode decode into access kind, size and extension
   always_comb begin
      is_ld = 1'b0;
      is_st = 1'b0;
      sext  = 1'b0;
      sz    = SZ_W;
      case (op)
         OP_SW:  begin is_st = 1'b1; sz = SZ_W; end
         OP_SH:  begin is_st = 1'b1; sz = SZ_H; end
         OP_SB:  begin is_st = 1'b1; sz = SZ_B; end
         OP_LW:  begin is_ld = 1'b1; sz = SZ_W; end
         OP_LH:  begin is_ld = 1'b1; sz = SZ_H; sext = 1'b1; end
         OP_LHU: begin is_ld = 1'b1; sz = SZ_H; end
         OP_LB:  begin is_ld = 1'b1; sz = SZ_B; sext = 1'b1; end
         OP_LBU: begin is_ld = 1'b1; sz = SZ_B; end
         default: ;
      endcase
   end

   assign off    = M_ALUO - BASE;
   assign idx    = off[ADDR_W+1:2];
   assign lane   = off[1:0];
   assign in_rng = {1'b0, off} < LIMIT;

   // Alignment rule depends on access size
   always_comb begin
      algn = 1'b1;
      case (sz)
         SZ_W:    algn = (lane == 2'b00);
         SZ_H:    algn = ~lane[0];
         default: algn = 1'b1;
      endcase
   end

   assign err    = ~(in_rng & algn);
   assign M_AdEL = is_ld & err;
   assign M_AdES = is_st & err;
   assign st_ok  = is_st & ~err;

   // Out-of-range indices never reach a write or a visible read
   assign rword = mem_q[idx];

   // Byte enables and lane-replicated store data
   always_comb begin
      be    = 4'b0000;
      wdata = M_rt;
      case (sz)
         SZ_W: begin
            be    = 4'b1111;
            wdata = M_rt;
         end
         SZ_H: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{M_rt[15:0]}};
         end
         default: begin
            be    = 4'b0001 << lane;
            wdata = {4{M_rt[7:0]}};
         end
      endcase
   end

   // Merge enabled bytes into the currently stored word
   always_comb begin
      wmerge = rword;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            wmerge[8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end

   // Lane select and sign/zero extension of the read word
   always_comb begin
      hsel  = lane[1] ? rword[31:16] : rword[15:0];
      bsel  = rword[8*lane +: 8];
      ldata = rword;
      case (sz)
         SZ_W:    ldata = rword;
         SZ_H:    ldata = {{16{sext & hsel[15]}}, hsel};
         default: ldata = {{24{sext & bsel[7]}}, bsel};
      endcase
   end

   assign M_DMRD = (is_ld & ~err) ? ldata : 32'h0;

   assign wcnt_d = wcnt_q + {31'h0, st_ok};
   assign M_wcnt = wcnt_q;

   // Memory array and committed-store counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wcnt_q <= '0;
      end else begin
         if (st_ok) begin
            mem_q[idx] <= wmerge;
         end
         wcnt_q <= wcnt_d;
      end
   end

`ifdef DM_DISPLAY_EN
   // Trace each committed store with its merged word
   always @(posedge clk) begin
      if (rst && st_ok) begin
         $display("@%08h: *%08h <= %08h",
                  M_PC, {M_ALUO[31:2], 2'b00}, wmerge);
      end
   end
`endif

   assign unused_ok = ^{M_PC, M_IR[25:0]};

endmodule
